// File: rtl/data_bus_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus a 16-byte MMIO window
// (CYCLE, WRCNT, TOHOST, SCRATCH). Define DBR_RAM_CLEAR_ON_RESET_EN to clear RAM on rst.
module data_bus_responder #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic [31:0] tohost_code,
    output logic        bus_err,
    output logic [31:0] store_count
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        REG_CYCLE   = 2'd0,
        REG_WRCNT   = 2'd1,
        REG_TOHOST  = 2'd2,
        REG_SCRATCH = 2'd3
    } reg_sel_e;

    logic [31:0] ram_q [DEPTH];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] wrcnt_q, wrcnt_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] code_q, code_d;
    logic        done_q, done_d;
    logic        bus_err_q, bus_err_d;

    logic          aligned;
    logic          is_ram;
    logic          is_mmio;
    logic [31:0]   mmio_off;
    reg_sel_e      reg_sel;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          err_now;

    // Address decode; the MMIO test uses a wrapping subtract so one compare covers both bounds.
    always_comb begin
        aligned  = (ALUResult[1:0] == 2'b00);
        mmio_off = ALUResult - MMIO_BASE;
        is_ram   = (ALUResult < RAM_BYTES);
        is_mmio  = (mmio_off < 32'd16);
        reg_sel  = reg_sel_e'(ALUResult[3:2]);
        ram_idx  = ALUResult[AW+1:2];
        ram_we   = MemWrite && aligned && is_ram && !rst;
    end

    // Combinational load path: RAM writes land on the edge, so a same-cycle read sees old data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        ReadData = '0;
        if (MemRead && aligned) begin
            if (is_ram) begin
                ReadData = ram_q[ram_idx];
            end else if (is_mmio) begin
                case (reg_sel)
                    REG_CYCLE:   ReadData = cycle_q;
                    REG_WRCNT:   ReadData = wrcnt_q;
                    REG_TOHOST:  ReadData = code_q;
                    REG_SCRATCH: ReadData = scratch_q;
                endcase
            end
        end
    end

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        wrcnt_d   = wrcnt_q;
        scratch_d = scratch_q;
        code_d    = code_q;
        done_d    = done_q;
        err_now   = 1'b0;

        if (ram_we) begin
            wrcnt_d = wrcnt_q + 32'd1;
        end

        if (MemWrite && aligned && is_mmio) begin
            case (reg_sel)
                REG_CYCLE, REG_WRCNT: err_now = 1'b1;
                REG_TOHOST: begin
                    if (!done_q && (WriteData != 32'd0)) begin
                        done_d = 1'b1;
                        code_d = WriteData;
                    end
                end
                REG_SCRATCH: scratch_d = WriteData;
            endcase
        end

        if ((MemRead || MemWrite) && (!aligned || (!is_ram && !is_mmio))) begin
            err_now = 1'b1;
        end
        if (MemRead && MemWrite) begin
            err_now = 1'b1;
        end

        bus_err_d = bus_err_q | err_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q   <= '0;
            wrcnt_q   <= '0;
            scratch_q <= '0;
            code_q    <= '0;
            done_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            cycle_q   <= cycle_d;
            wrcnt_q   <= wrcnt_d;
            scratch_q <= scratch_d;
            code_q    <= code_d;
            done_q    <= done_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef DBR_RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (ram_we) begin
            ram_q[ram_idx] <= WriteData;
        end
    end
`else
    // NOTE: the RAM is deliberately left without reset so it maps onto plain block RAM;
    // ram_we is gated by rst so stores sampled during reset are still dropped.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= WriteData;
        end
    end
`endif

    assign done        = done_q;
    assign tohost_code = code_q;
    assign bus_err     = bus_err_q;
    assign store_count = wrcnt_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed self-checking bench for data_bus_responder (DEPTH=64, MMIO_BASE=0x1000).
module tb_data_bus_responder;

    localparam int unsigned DEPTH     = 64;
    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        done;
    logic [31:0] tohost_code;
    logic        bus_err;
    logic [31:0] store_count;

    int checks = 0;
    int errors = 0;

    data_bus_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .done       (done),
        .tohost_code(tohost_code),
        .bus_err    (bus_err),
        .store_count(store_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one bus cycle just after the falling edge; outputs are stable for checking on return.
    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemRead   = rd;
        MemWrite  = wr;
        ALUResult = a;
        WriteData = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] exp_retain;
    logic [31:0] exp_dropped;

    initial begin
        // Reset state
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_code", tohost_code, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_wrcnt", store_count, 32'd0);

        // CYCLE counter: 10 edges after release reads 10, then keeps counting
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        drive(1'b1, 1'b0, MMIO_BASE, 32'd0);
        check("cycle_10", ReadData, 32'd10);
        drive(1'b1, 1'b0, MMIO_BASE, 32'd0);
        check("cycle_11", ReadData, 32'd11);
        check("cycle_no_err", {31'd0, bus_err}, 32'd0);
        drive(1'b0, 1'b1, MMIO_BASE, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, MMIO_BASE, 32'd0);
        check("cycle_write_ignored", ReadData, 32'd13);
        check("cycle_write_err", {31'd0, bus_err}, 32'd1);

        // Store then load RAM word 0
        apply_reset();
        drive(1'b0, 1'b1, 32'd0, 32'h1E);
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        check("ram_load0", ReadData, 32'h1E);
        check("ram_wrcnt", store_count, 32'd1);
        check("ram_no_err", {31'd0, bus_err}, 32'd0);
        drive(1'b1, 1'b0, MMIO_BASE + 32'd4, 32'd0);
        check("wrcnt_mmio", ReadData, 32'd1);

        // Misaligned store is dropped and flags an error
        drive(1'b0, 1'b1, 32'd2, 32'hAA);
        drive(1'b1, 1'b0, 32'd0, 32'd0);
        check("misalign_word0", ReadData, 32'h1E);
        check("misalign_err", {31'd0, bus_err}, 32'd1);
        check("misalign_wrcnt", store_count, 32'd1);

        // Unmapped read just past RAM: returns 0, error appears on the next edge
        apply_reset();
        drive(1'b1, 1'b0, DEPTH * 4, 32'd0);
        check("unmapped_data", ReadData, 32'd0);
        check("unmapped_err_same_cycle", {31'd0, bus_err}, 32'd0);
        idle();
        check("unmapped_err", {31'd0, bus_err}, 32'd1);

        // Simultaneous read and write at the same address
        apply_reset();
        drive(1'b0, 1'b1, 32'd8, 32'd5);
        drive(1'b1, 1'b1, 32'd8, 32'd9);
        check("rw_old", ReadData, 32'd5);
        drive(1'b1, 1'b0, 32'd8, 32'd0);
        check("rw_new", ReadData, 32'd9);
        check("rw_err", {31'd0, bus_err}, 32'd1);
        check("rw_wrcnt", store_count, 32'd2);

        // TOHOST, SCRATCH, MemRead low, window edge
        apply_reset();
        drive(1'b0, 1'b1, MMIO_BASE + 32'd8, 32'd0);
        idle();
        check("tohost_zero", {31'd0, done}, 32'd0);
        drive(1'b0, 1'b1, MMIO_BASE + 32'd8, 32'd1);
        idle();
        check("tohost_done", {31'd0, done}, 32'd1);
        check("tohost_code1", tohost_code, 32'd1);
        drive(1'b0, 1'b1, MMIO_BASE + 32'd8, 32'd2);
        idle();
        check("tohost_sticky", tohost_code, 32'd1);
        drive(1'b1, 1'b0, MMIO_BASE + 32'd8, 32'd0);
        check("tohost_read", ReadData, 32'd1);
        drive(1'b0, 1'b1, MMIO_BASE + 32'hC, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, MMIO_BASE + 32'hC, 32'd0);
        check("scratch_read", ReadData, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, MMIO_BASE + 32'hC, 32'd0);
        check("read_low_zero", ReadData, 32'd0);
        check("tohost_no_err", {31'd0, bus_err}, 32'd0);
        drive(1'b1, 1'b0, MMIO_BASE + 32'h10, 32'd0);
        check("window_end_data", ReadData, 32'd0);
        idle();
        check("window_end_err", {31'd0, bus_err}, 32'd1);
        @(negedge clk);
        rst      = 1'b1;
        MemRead  = 1'b1;
        ALUResult = MMIO_BASE + 32'hC;
        #1;
        check("rst_done_clear", {31'd0, done}, 32'd0);
        check("rst_code_clear", tohost_code, 32'd0);
        check("rst_scratch_clear", ReadData, 32'd0);
        check("rst_err_clear", {31'd0, bus_err}, 32'd0);
        @(negedge clk);
        rst     = 1'b0;
        MemRead = 1'b0;

        // RAM retention across reset and stores dropped while in reset
        drive(1'b0, 1'b1, 32'd4, 32'h55);
        drive(1'b0, 1'b1, 32'd12, 32'h11);
        @(negedge clk);
        rst       = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ALUResult = 32'd12;
        WriteData = 32'h77;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        MemWrite = 1'b0;
`ifdef DBR_RAM_CLEAR_ON_RESET_EN
        exp_retain  = 32'h0;
        exp_dropped = 32'h0;
`else
        exp_retain  = 32'h55;
        exp_dropped = 32'h11;
`endif
        drive(1'b1, 1'b0, 32'd4, 32'd0);
        check("retain_word1", ReadData, exp_retain);
        drive(1'b1, 1'b0, 32'd12, 32'd0);
        check("rst_write_dropped", ReadData, exp_dropped);
        check("rst_write_wrcnt", store_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Slave-side data-memory responder for the single-cycle core's load/store port: MemRead, MemWrite, ALUResult, WriteData in; ReadData out.
- Combines word-addressed RAM with a small MMIO register window: cycle counter, store counter, scratch register and a "tohost" test-completion register.
- Replaces ad-hoc behavioural data memory in system benches and FPGA top-levels.
- Reads are combinational; the core has no stall path, so data must arrive in the same cycle. Writes commit on the rising edge.

Parameters:
- DEPTH, 64: RAM words; power of two, 4..4096.
- MMIO_BASE, 32'h0000_1000: byte base of the MMIO window. Must be 16-byte aligned and at or above DEPTH*4.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  load strobe from core
- MemWrite  in  1  store strobe from core
- ALUResult  in  32  byte address
- WriteData  in  32  store data
- ReadData  out  32  load data, combinational
- done  out  1  sticky; set by first nonzero write to TOHOST
- tohost_code  out  32  value latched with done
- bus_err  out  1  sticky error flag
- store_count  out  32  mirror of the WRCNT register

Behaviour:
- Reset is asynchronous. While rst is high:
  - done=0, tohost_code=0, bus_err=0.
  - CYCLE=0, WRCNT=0, SCRATCH=0.
  - A MemWrite sampled on an edge where rst is high is dropped.
- Address decode (A = ALUResult):
  - RAM when A < DEPTH*4; index A[log2(DEPTH)+1:2].
  - MMIO when MMIO_BASE <= A < MMIO_BASE+16; offset A[3:2].
  - Anything else is unmapped.
- MMIO registers:
  - 0x0 CYCLE, RO: increments every clk edge after reset deasserts; wraps 32'hFFFF_FFFF -> 0.
  - 0x4 WRCNT, RO: increments on every committed RAM store; wraps.
  - 0x8 TOHOST, WO:
    - A write of a nonzero value while done=0 sets done=1 and tohost_code=WriteData.
    - A zero write, or any write once done=1, is ignored. No error is raised.
    - Reads return tohost_code.
  - 0xC SCRATCH, RW.
- Read path, when MemRead=1:
  - RAM returns the word.
  - MMIO returns the register value.
  - Unmapped or misaligned addresses return 0.
- When MemRead=0, ReadData=0.
- Write path: a RAM or SCRATCH write commits on the rising edge when MemWrite=1 and the address is aligned and writable.
- Read-during-write to the same address returns the old contents in that cycle; the new value is visible from the next cycle.
- bus_err is set on the next edge, and stays set until reset, by any of:
  - Access (read or write) with A[1:0] != 0. A misaligned write is not committed.
  - Access to an unmapped address.
  - Write to CYCLE or WRCNT. The write is ignored.
  - MemRead and MemWrite both high in one cycle. The write still commits; the read returns the pre-write value.
- No access: RAM and registers hold; CYCLE still counts.
- Reset mid-program: all registers clear immediately. RAM contents follow the optional-feature rule below.

Optional Feature:
- Macro: DBR_RAM_CLEAR_ON_RESET_EN.
- Defined: all RAM words are cleared to 0 asynchronously with rst, and a load after reset returns 0.
- Undefined: RAM has no reset, so contents survive rst assertion and power-up contents are X. A RAM load after reset returns the last stored value.

Test Plan:
- Store/load RAM: write 32'h1E at A=0, then read A=0 the next cycle -> ReadData=32'h1E, WRCNT=1, bus_err=0.
- Same-cycle read/write: with old word 5 at A=8, drive MemRead=MemWrite=1 with data 9 at A=8 -> ReadData=5 that cycle, 9 the next cycle, bus_err=1.
- Misaligned and unmapped accesses:
  - Write 32'hAA at A=2 -> RAM word 0 unchanged, bus_err=1.
  - After reset, read A=DEPTH*4 -> ReadData=0, bus_err=1.
- CYCLE counter: release rst, wait 10 edges, read MMIO_BASE+0 -> 10. Write to CYCLE -> value unchanged, bus_err=1.
- TOHOST:
  - Write 0 to MMIO_BASE+8 -> done=0.
  - Write 32'h1 -> done=1, tohost_code=1.
  - Write 32'h2 -> tohost_code stays 1.
  - Assert rst -> done=0.
- Reset retention: store 32'h55 at A=4, pulse rst for 2 cycles, then read A=4 -> 0 with DBR_RAM_CLEAR_ON_RESET_EN defined, 32'h55 without.
